edge_detect_bank: RTL and testbench
===================================

# edge_detect_bank

Multi-channel successor to the single-bit rising-edge detector. It takes WIDTH asynchronous inputs such as buttons, switches or external strobes, and for each channel:
- synchronises it to clk;
- debounces it with a per-channel stability counter;
- reports rising and/or falling edges, selected per channel, as one-cycle pulses and as sticky flags.

It sits between board-level inputs and the control logic and interrupt aggregation.

## Interface
- WIDTH, default 8: number of independent channels; must be at least 1.
- SYNC_STAGES, default 2: synchroniser flops per channel; must be at least 2.
- DEBOUNCE, default 4: consecutive clk cycles a new synchronised value must hold before it is accepted; must be at least 1. Counter width is $clog2(DEBOUNCE+1).

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- sig_in  in  WIDTH  raw asynchronous channel inputs.
- rise_en  in  WIDTH  per-channel enable for rising-edge reporting (synchronous to clk).
- fall_en  in  WIDTH  per-channel enable for falling-edge reporting (synchronous to clk).
- clr  in  WIDTH  per-channel sticky clear, active-high, sampled each cycle.
- level  out  WIDTH  debounced level per channel, registered.
- pulse  out  WIDTH  one-cycle edge pulse per channel, registered.
- sticky  out  WIDTH  latched edge flag per channel, registered.
- irq  out  1  OR-reduction of sticky, combinational from registers.

## Operation
- Reset value of every output is 0. Synchroniser flops, level, pulse, sticky and counters are all cleared asynchronously on rst=1.
- Channels are fully independent; no shared state.
- Synchroniser: sig_in[i] is shifted through SYNC_STAGES flops. s[i] denotes the last stage.
- Debounce, per channel, on each clk edge:
  - If s == level: cnt <= 0.
  - Else if cnt == DEBOUNCE-1: level <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any return of s to level before acceptance restarts the count. Glitches shorter than DEBOUNCE cycles never reach level.
- Edge event: this is the cycle in which level is updated.
  - rise_evt = update and s=1 and rise_en.
  - fall_evt = update and s=0 and fall_en.
  - Enables are sampled in the update cycle only.
- pulse[i] <= rise_evt|fall_evt. It is high for exactly one cycle, aligned with the new level value.
- Sticky: sticky[i] <= (sticky[i] & ~clr[i]) | evt. If an event and clr occur in the same cycle, set wins.
- irq = |sticky.
- Because level resets to 0, an input held high through reset produces a rising event after the latency, if rise_en=1. This is intended; it reports initial state.

## Timing
- Latency: the input changes and is stable before clk edge 1. s changes at edge SYNC_STAGES, and level, pulse and sticky update at edge SYNC_STAGES+DEBOUNCE. With defaults that is edge 6.
- Maximum event rate per channel: one edge per DEBOUNCE cycles after s settles.
- clr takes effect on the next edge; sticky reads 0 in the following cycle unless a new event coincides.
- rst asserted mid-count: the count is discarded, and the pending edge is lost and not reported after release.
- rst deasserts synchronously to clk at system level; the block adds no reset synchroniser.

## Test plan
- Reset and idle: hold rst=1 with sig_in=8'hFF, then release, with defaults and rise_en=8'hFF. Required: all outputs 0 during reset; pulse=8'hFF for one cycle at edge 6 after release; sticky=8'hFF; irq=1.
- Clean rising edge on channel 3 with rise_en[3]=1 and fall_en=0, input high at cycle 0. Required: level[3]=1 and pulse[3]=1 at edge 6 only; falling the input later gives level[3]=0 at +6 with no pulse and sticky unchanged.
- Glitch rejection: a 3-cycle high on channel 0 with DEBOUNCE=4. Required: level, pulse and sticky stay 0. A 4-cycle high is accepted, with pulse at edge 6 after the rise.
- Bounce: toggle channel 1 for 1-cycle periods for 10 cycles, then hold high. Required: exactly one pulse, 6 cycles after the final hold begins.
- Sticky clear: set sticky[2] via a rising edge, then assert clr[2] for one cycle. Required: sticky[2]=0 and irq=0 the next cycle. Then force clr[2]=1 in the same cycle as a new event; required: sticky[2]=1.
- Reset mid-count: assert rst 2 cycles after s changes on channel 5. Required: all outputs 0 and no pulse after release while sig_in[5] is back to 0.

Source files
------------

// File: rtl/edge_detect_bank.sv
// Multi-channel input conditioner: per-channel synchroniser, stability-counter
// debounce and selectable rising/falling edge reporting as pulses and sticky flags.
module edge_detect_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig_in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse,
    output logic [WIDTH-1:0] sticky,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_pulse;
    logic [WIDTH-1:0] r_sticky;

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_update;
    logic [WIDTH-1:0] w_rise_evt;
    logic [WIDTH-1:0] w_fall_evt;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CW-1:0]          r_cnt;

        // Shift the raw input through the synchroniser chain; the last stage is the clean sample.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= {SYNC_STAGES{1'b0}};
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in[g]};
            end
        end

        assign w_s[g]      = r_sync[SYNC_STAGES-1];
        assign w_update[g] = (w_s[g] != r_level[g]) && (r_cnt == CNT_LAST);

        // Stability counter: any return of the sample to the accepted level restarts the count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= CNT_ZERO;
            end else if (w_s[g] == r_level[g]) begin
                r_cnt <= CNT_ZERO;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt <= CNT_ZERO;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    // Enables only matter in the cycle the level is actually accepted.
    assign w_rise_evt = w_update &  w_s & rise_en;
    assign w_fall_evt = w_update & ~w_s & fall_en;

    // Accepted level, one-cycle edge pulse and sticky flags (a new event beats a clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level  <= {WIDTH{1'b0}};
            r_pulse  <= {WIDTH{1'b0}};
            r_sticky <= {WIDTH{1'b0}};
        end else begin
            r_level  <= (r_level & ~w_update) | (w_s & w_update);
            r_pulse  <= w_rise_evt | w_fall_evt;
            r_sticky <= (r_sticky & ~clr) | w_rise_evt | w_fall_evt;
        end
    end

    assign level  = r_level;
    assign pulse  = r_pulse;
    assign sticky = r_sticky;
    assign irq    = |r_sticky;

endmodule

// File: tb/tb_edge_detect_bank.sv
// Directed bench for edge_detect_bank with default parameters; inputs are driven
// on the falling edge and outputs sampled on later falling edges.
module tb_edge_detect_bank;

    logic       clk;
    logic       rst;
    logic [7:0] sig_in;
    logic [7:0] rise_en;
    logic [7:0] fall_en;
    logic [7:0] clr;
    logic [7:0] level;
    logic [7:0] pulse;
    logic [7:0] sticky;
    logic       irq;

    int n_vec;
    int n_err;

    edge_detect_bank #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .DEBOUNCE(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .rise_en(rise_en),
        .fall_en(fall_en),
        .clr    (clr),
        .level  (level),
        .pulse  (pulse),
        .sticky (sticky),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst     = 1'b1;
        sig_in  = 8'h00;
        rise_en = 8'h00;
        fall_en = 8'h00;
        clr     = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] exp_p;
        rst     = 1'b1;
        sig_in  = 8'hFF;
        rise_en = 8'hFF;
        fall_en = 8'h00;
        clr     = 8'h00;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({level, pulse, sticky} !== 24'h000000 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold got level=%h pulse=%h sticky=%h irq=%b exp all 0", level, pulse, sticky, irq);
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            exp_p = (k == 6) ? 8'hFF : 8'h00;
            n_vec++;
            if (pulse !== exp_p) begin
                n_err++;
                $display("FAIL reset_pulse edge=%0d got=%h exp=%h", k, pulse, exp_p);
            end
            if (k >= 6) begin
                n_vec++;
                if (level !== 8'hFF || sticky !== 8'hFF || irq !== 1'b1) begin
                    n_err++;
                    $display("FAIL reset_initstate edge=%0d got level=%h sticky=%h irq=%b exp FF FF 1", k, level, sticky, irq);
                end
            end
        end
    endtask

    task automatic test_clean_rise_fall();
        logic [7:0] exp_l;
        logic [7:0] exp_p;
        do_reset();
        rise_en = 8'h08;
        fall_en = 8'h00;
        sig_in  = 8'h08;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_l = (k >= 6) ? 8'h08 : 8'h00;
            exp_p = (k == 6) ? 8'h08 : 8'h00;
            n_vec++;
            if (level !== exp_l || pulse !== exp_p) begin
                n_err++;
                $display("FAIL rise3 edge=%0d got level=%h pulse=%h exp level=%h pulse=%h", k, level, pulse, exp_l, exp_p);
            end
        end
        sig_in = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_l = (k >= 6) ? 8'h00 : 8'h08;
            n_vec++;
            if (level !== exp_l || pulse !== 8'h00 || sticky !== 8'h08) begin
                n_err++;
                $display("FAIL fall3_noreport edge=%0d got level=%h pulse=%h sticky=%h exp level=%h pulse=00 sticky=08", k, level, pulse, sticky, exp_l);
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] exp_l;
        logic [7:0] exp_p;
        do_reset();
        rise_en = 8'hFF;
        sig_in  = 8'h01;
        repeat (3) @(negedge clk);
        sig_in = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_vec++;
            if (level !== 8'h00 || pulse !== 8'h00 || sticky !== 8'h00) begin
                n_err++;
                $display("FAIL glitch3 cyc=%0d got level=%h pulse=%h sticky=%h exp 00 00 00", k, level, pulse, sticky);
            end
        end
        sig_in = 8'h01;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 4) sig_in = 8'h00;
            exp_p = (k == 6) ? 8'h01 : 8'h00;
            exp_l = (k >= 6) ? 8'h01 : 8'h00;
            n_vec++;
            if (pulse !== exp_p || level !== exp_l) begin
                n_err++;
                $display("FAIL glitch4 edge=%0d got pulse=%h level=%h exp pulse=%h level=%h", k, pulse, level, exp_p, exp_l);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] v;
        int         n_pulse;
        int         first_k;
        do_reset();
        rise_en = 8'h02;
        fall_en = 8'h02;
        v       = 8'h02;
        n_pulse = 0;
        for (int k = 0; k < 10; k++) begin
            sig_in = v;
            v      = v ^ 8'h02;
            @(negedge clk);
            if (pulse !== 8'h00) n_pulse++;
        end
        sig_in  = 8'h02;
        first_k = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (pulse !== 8'h00) begin
                n_pulse++;
                if (first_k < 0) first_k = k;
            end
        end
        n_vec++;
        if (n_pulse != 1) begin
            n_err++;
            $display("FAIL bounce_count got=%0d exp=1", n_pulse);
        end
        n_vec++;
        if (first_k != 6) begin
            n_err++;
            $display("FAIL bounce_latency got=%0d exp=6", first_k);
        end
        n_vec++;
        if (level !== 8'h02) begin
            n_err++;
            $display("FAIL bounce_level got=%h exp=02", level);
        end
    endtask

    task automatic test_sticky_clr();
        do_reset();
        rise_en = 8'h04;
        fall_en = 8'h04;
        sig_in  = 8'h04;
        repeat (7) @(negedge clk);
        n_vec++;
        if (sticky !== 8'h04 || irq !== 1'b1) begin
            n_err++;
            $display("FAIL sticky_set got sticky=%h irq=%b exp 04 1", sticky, irq);
        end
        clr = 8'h04;
        @(negedge clk);
        clr = 8'h00;
        n_vec++;
        if (sticky !== 8'h00 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL sticky_clear got sticky=%h irq=%b exp 00 0", sticky, irq);
        end
        sig_in = 8'h00;
        repeat (5) @(negedge clk);
        n_vec++;
        if (sticky !== 8'h00 || level !== 8'h04) begin
            n_err++;
            $display("FAIL sticky_prefall got sticky=%h level=%h exp 00 04", sticky, level);
        end
        clr = 8'h04;
        @(negedge clk);
        clr = 8'h00;
        n_vec++;
        if (sticky !== 8'h04 || pulse !== 8'h04 || irq !== 1'b1) begin
            n_err++;
            $display("FAIL sticky_setwins got sticky=%h pulse=%h irq=%b exp 04 04 1", sticky, pulse, irq);
        end
    endtask

    task automatic test_enables();
        do_reset();
        rise_en = 8'h0F;
        fall_en = 8'hF0;
        sig_in  = 8'hFF;
        repeat (6) @(negedge clk);
        n_vec++;
        if (pulse !== 8'h0F || level !== 8'hFF || sticky !== 8'h0F) begin
            n_err++;
            $display("FAIL enables_rise got pulse=%h level=%h sticky=%h exp 0F FF 0F", pulse, level, sticky);
        end
        sig_in = 8'h00;
        repeat (6) @(negedge clk);
        n_vec++;
        if (pulse !== 8'hF0 || level !== 8'h00 || sticky !== 8'hFF) begin
            n_err++;
            $display("FAIL enables_fall got pulse=%h level=%h sticky=%h exp F0 00 FF", pulse, level, sticky);
        end
    endtask

    task automatic test_reset_midcount();
        do_reset();
        rise_en = 8'hFF;
        fall_en = 8'hFF;
        sig_in  = 8'h20;
        repeat (4) @(negedge clk);
        rst    = 1'b1;
        sig_in = 8'h00;
        #1;
        n_vec++;
        if ({level, pulse, sticky} !== 24'h000000 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_hold got level=%h pulse=%h sticky=%h irq=%b exp all 0", level, pulse, sticky, irq);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_vec++;
            if ({level, pulse, sticky} !== 24'h000000 || irq !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_after cyc=%0d got level=%h pulse=%h sticky=%h irq=%b exp all 0", k, level, pulse, sticky, irq);
            end
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        sig_in  = 8'h00;
        rise_en = 8'h00;
        fall_en = 8'h00;
        clr     = 8'h00;
        test_reset();
        test_clean_rise_fall();
        test_glitch();
        test_bounce();
        test_sticky_clr();
        test_enables();
        test_reset_midcount();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
